// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Start/busy/done handshake; bcd only changes on the done edge.
module bin2bcd_seq #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int SW = 4 * DIGITS;

   typedef enum logic {IDLE, CONV} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [SW-1:0]    scratch_q, scratch_d;
   logic [SW-1:0]    bcd_q, bcd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [SW-1:0]       scratch_adj;
   logic [SW+WIDTH-1:0] joined_shl;

   // Digits >= 5 get +3 before the shift so they carry correctly into the next decade.
   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
         assign scratch_adj[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5)
                                         ? scratch_q[4*gi +: 4] + 4'd3
                                         : scratch_q[4*gi +: 4];
      end
   endgenerate

   assign joined_shl = {scratch_adj, shift_q} << 1;

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      scratch_d = scratch_q;
      bcd_d     = bcd_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = CONV;
               busy_d    = 1'b1;
               shift_d   = bin;
               scratch_d = '0;
               cnt_d     = CW'(WIDTH);
            end
         end
         CONV: begin
            {scratch_d, shift_d} = joined_shl;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               bcd_d   = joined_shl[WIDTH +: SW];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         scratch_q <= '0;
         bcd_q     <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         scratch_q <= scratch_d;
         bcd_q     <= bcd_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign bcd  = bcd_q;

endmodule
